// File: rtl/conv_encoder.sv
// Rate-1/2 K=3 convolutional encoder (g0=7, g1=5) with optional zero tail; one-cycle latency.
// Single-entry output slot: new pairs load only when the slot is empty or being taken this cycle.
module conv_encoder #(
  parameter int unsigned TAIL_EN = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             refresh,
  input  logic             bit_in,
  input  logic             valid_in,
  input  logic             last_in,
  output logic             ready_in,
  output logic [1:0]       bit_pair_out,
  output logic             valid_out,
  input  logic             out_ready,
  output logic             frame_done,
  output logic [CNT_W-1:0] bit_count
);

  localparam logic TAIL_ON = (TAIL_EN != 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_TAIL1 = 2'd2,
    ST_TAIL2 = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_s;
  logic [1:0]       r_pair;
  logic             r_valid;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;

  logic             w_slot_free;
  logic             w_in_data;
  logic             w_ready;
  logic             w_accept;
  logic             w_tail_step;
  logic             w_load;
  logic             w_u;
  logic             w_done;
  logic [1:0]       w_pair;
  logic [1:0]       w_s_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else if (refresh) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (last_in) w_state_nxt = TAIL_ON ? ST_TAIL1 : ST_IDLE;
          else         w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_accept && last_in) w_state_nxt = TAIL_ON ? ST_TAIL1 : ST_IDLE;
      end
      ST_TAIL1: begin
        if (w_slot_free) w_state_nxt = ST_TAIL2;
      end
      ST_TAIL2: begin
        if (w_slot_free) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded control: handshake, tail stepping and frame completion
  always_comb begin
    w_slot_free = !r_valid || out_ready;
    w_in_data   = (r_state == ST_IDLE) || (r_state == ST_DATA);
    w_ready     = w_in_data && w_slot_free;
    w_accept    = valid_in && w_ready;
    w_tail_step = !w_in_data && w_slot_free;
    w_load      = w_accept || w_tail_step;
    w_u         = w_accept && bit_in;
    w_done      = (w_accept && last_in && !TAIL_ON) ||
                  ((r_state == ST_TAIL2) && w_slot_free);
  end

  always_comb begin
    w_pair  = {w_u ^ r_s[1] ^ r_s[0], w_u ^ r_s[0]};
    // Without a tail the register must be flushed so the next frame starts from 00
    w_s_nxt = w_done ? 2'b00 : {w_u, r_s[1]};
    if (r_state == ST_IDLE) begin
      w_cnt_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (r_cnt != {CNT_W{1'b1}}) begin
      w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s     <= 2'b00;
      r_pair  <= 2'b00;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else if (refresh) begin
      r_s     <= 2'b00;
      r_pair  <= 2'b00;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_load) begin
        r_pair <= w_pair;
        r_s    <= w_s_nxt;
      end
      r_valid <= w_load || !w_slot_free;
      r_done  <= w_done;
      if (w_accept) r_cnt <= w_cnt_nxt;
    end
  end

  assign ready_in     = w_ready;
  assign bit_pair_out = r_pair;
  assign valid_out    = r_valid;
  assign frame_done   = r_done;
  assign bit_count    = r_cnt;

endmodule

// File: tb/tb_conv_encoder.sv
// Bench for conv_encoder: TAIL_EN=1 instance (index 1) and TAIL_EN=0 instance (index 0)
// checked every cycle against a bit-history reference model, plus directed pair sequences.
module tb_conv_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       refresh;
  logic       out_ready;
  logic       vin   [2];
  logic       bin   [2];
  logic       lin   [2];
  logic       rdy   [2];
  logic       vout  [2];
  logic       fdone [2];
  logic [1:0] pout  [2];
  logic [7:0] cnt   [2];

  conv_encoder #(.TAIL_EN(0), .CNT_W(8)) u_notail (
    .clk(clk), .rst(rst), .refresh(refresh),
    .bit_in(bin[0]), .valid_in(vin[0]), .last_in(lin[0]), .ready_in(rdy[0]),
    .bit_pair_out(pout[0]), .valid_out(vout[0]), .out_ready(out_ready),
    .frame_done(fdone[0]), .bit_count(cnt[0])
  );

  conv_encoder #(.TAIL_EN(1), .CNT_W(8)) u_tail (
    .clk(clk), .rst(rst), .refresh(refresh),
    .bit_in(bin[1]), .valid_in(vin[1]), .last_in(lin[1]), .ready_in(rdy[1]),
    .bit_pair_out(pout[1]), .valid_out(vout[1]), .out_ready(out_ready),
    .frame_done(fdone[1]), .bit_count(cnt[1])
  );

  always #5 clk = ~clk;

  // Reference model: the code pair is computed from the frame's bit history
  logic       hist   [2][512];
  int         hlen   [2];
  int         ndata  [2];
  int         pend   [2];
  bit         open_f [2];
  bit         m_slot [2];
  bit         m_done [2];
  logic [1:0] m_pair [2];
  bit         acc    [2];
  logic [1:0] lg     [2][64];
  int         ln     [2];
  int         npulse [2];
  int         vectors = 0;
  int         miscompares = 0;

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, d, obs, exp);
    end
  endtask

  task automatic fail_timeout(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s: observed timeout expected completion", tag);
  endtask

  function automatic logic hbit(input int d, input int k);
    if (k < 0) return 1'b0;
    return hist[d][k % 512];
  endfunction

  function automatic logic [1:0] pair_at(input int d, input int k);
    logic u, a, b;
    u = hbit(d, k);
    a = hbit(d, k - 1);
    b = hbit(d, k - 2);
    return {u ^ a ^ b, u ^ b};
  endfunction

  task automatic mreset(input int d);
    hlen[d] = 0; ndata[d] = 0; pend[d] = 0; open_f[d] = 0;
    m_slot[d] = 0; m_done[d] = 0; m_pair[d] = 2'b00; acc[d] = 0;
  endtask

  task automatic model_reset();
    mreset(0);
    mreset(1);
  endtask

  task automatic clear_log();
    for (int d = 0; d < 2; d++) begin
      ln[d] = 0;
      npulse[d] = 0;
    end
  endtask

  task automatic model_cycle(input int d);
    bit free, ready, tail_en, load, fin;
    logic [1:0] p;
    int expc;
    tail_en = (d == 1);
    free  = !m_slot[d] || out_ready;
    ready = (pend[d] == 0) && free;
    expc  = (ndata[d] > 255) ? 255 : ndata[d];
    chk("ready_in", d, rdy[d], ready);
    chk("valid_out", d, vout[d], m_slot[d]);
    if (m_slot[d]) chk("bit_pair_out", d, pout[d], m_pair[d]);
    chk("frame_done", d, fdone[d], m_done[d]);
    chk("bit_count", d, cnt[d], expc);
    if (fdone[d] === 1'b1) npulse[d]++;
    acc[d] = vin[d] && ready;
    if (!rst || refresh) begin
      mreset(d);
      return;
    end
    if (m_slot[d] && out_ready && ln[d] < 64) begin
      lg[d][ln[d]] = m_pair[d];
      ln[d]++;
    end
    load = 0; fin = 0; p = 2'b00;
    if (acc[d]) begin
      if (!open_f[d]) begin
        hlen[d] = 0; ndata[d] = 0; open_f[d] = 1;
      end
      hist[d][hlen[d] % 512] = bin[d];
      p = pair_at(d, hlen[d]);
      hlen[d]++; ndata[d]++; load = 1;
      if (lin[d]) begin
        open_f[d] = 0;
        if (tail_en) pend[d] = 2;
        else fin = 1;
      end
    end else if (pend[d] > 0 && free) begin
      hist[d][hlen[d] % 512] = 1'b0;
      p = pair_at(d, hlen[d]);
      hlen[d]++; pend[d]--; load = 1;
      fin = (pend[d] == 0);
    end
    m_done[d] = load && fin;
    m_slot[d] = load ? 1'b1 : (free ? 1'b0 : m_slot[d]);
    if (load) m_pair[d] = p;
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle(0);
    model_cycle(1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic b, input logic l);
    int budget;
    vin[d] = 1'b1; bin[d] = b; lin[d] = l;
    budget = 0;
    do begin
      step();
      budget++;
    end while (!acc[d] && budget < 50);
    if (!acc[d]) fail_timeout("send");
  endtask

  task automatic drain();
    int budget;
    vin[0] = 1'b0; vin[1] = 1'b0; lin[0] = 1'b0; lin[1] = 1'b0;
    out_ready = 1'b1;
    budget = 0;
    while ((m_slot[0] || m_slot[1] || pend[0] != 0 || pend[1] != 0) && budget < 100) begin
      step();
      budget++;
    end
    if (budget >= 100) fail_timeout("drain");
  endtask

  task automatic check_log(input int d, input int n, input logic [15:0] ex);
    chk("log_len", d, ln[d], n);
    for (int i = 0; i < n && i < ln[d]; i++)
      chk("log_pair", d, lg[d][i], ex[2*(n-1-i) +: 2]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no completion expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; refresh = 1'b0; out_ready = 1'b1;
    for (int d = 0; d < 2; d++) begin
      vin[d] = 1'b0; bin[d] = 1'b0; lin[d] = 1'b0;
    end
    model_reset();
    clear_log();
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", d, vout[d], 1'b0);
      chk("rst_pair", d, pout[d], 2'b00);
      chk("rst_done", d, fdone[d], 1'b0);
      chk("rst_count", d, cnt[d], 8'd0);
      chk("rst_ready", d, rdy[d], 1'b1);
    end
    @(posedge clk); #1;
    rst = 1'b1;

    // Basic frame 1,0,1,1 with tail
    clear_log();
    send(1, 1, 0); send(1, 0, 0); send(1, 1, 0); send(1, 1, 1);
    drain();
    check_log(1, 6, {4'b0, 2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11});
    chk("basic_count", 1, cnt[1], 8'd4);
    chk("basic_pulses", 1, npulse[1], 1);

    // Backpressure after the second pair
    clear_log();
    send(1, 1, 0); send(1, 0, 0);
    out_ready = 1'b0;
    bin[1] = 1'b1; lin[1] = 1'b0;
    repeat (3) begin
      step();
      chk("bp_hold", 1, pout[1], 2'b10);
      chk("bp_ready", 1, rdy[1], 1'b0);
    end
    out_ready = 1'b1;
    send(1, 1, 0); send(1, 1, 1);
    drain();
    check_log(1, 6, {4'b0, 2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11});

    // Back-to-back frames with valid held high
    clear_log();
    send(1, 1, 1); send(1, 1, 0); send(1, 1, 1);
    drain();
    check_log(1, 7, {2'b0, 2'b11, 2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b11});
    chk("b2b_pulses", 1, npulse[1], 2);

    // Refresh mid-frame
    send(1, 1, 0); send(1, 0, 0);
    vin[1] = 1'b0;
    refresh = 1'b1;
    step();
    refresh = 1'b0;
    chk("refresh_valid", 1, vout[1], 1'b0);
    chk("refresh_count", 1, cnt[1], 8'd0);
    clear_log();
    send(1, 1, 1);
    drain();
    check_log(1, 3, {10'b0, 2'b11, 2'b10, 2'b11});

    // Async reset while in TAIL1
    send(1, 1, 0); send(1, 1, 1);
    vin[1] = 1'b0; lin[1] = 1'b0;
    chk("pre_arst_valid", 1, vout[1], 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 1, vout[1], 1'b0);
    chk("arst_pair", 1, pout[1], 2'b00);
    chk("arst_done", 1, fdone[1], 1'b0);
    model_reset();
    step();
    rst = 1'b1;
    chk("arst_ready", 1, rdy[1], 1'b1);

    // No-tail instance: two frames
    clear_log();
    send(0, 1, 0); send(0, 1, 1); send(0, 1, 1);
    drain();
    check_log(0, 3, {10'b0, 2'b11, 2'b01, 2'b11});
    chk("notail_pulses", 0, npulse[0], 2);

    // Counter saturation on a long frame
    for (int i = 0; i < 259; i++) send(1, 1'($urandom_range(0, 1)), 0);
    send(1, 1, 1);
    drain();
    chk("sat_count", 1, cnt[1], 8'd255);

    // Randomized traffic, backpressure and occasional refresh
    for (int c = 0; c < 1500; c++) begin
      for (int d = 0; d < 2; d++) begin
        vin[d] = ($urandom_range(0, 3) != 0);
        bin[d] = 1'($urandom_range(0, 1));
        lin[d] = ($urandom_range(0, 5) == 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      refresh   = ($urandom_range(0, 99) == 0);
      step();
    end
    refresh = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
